// File: rtl/cam_lookup_ctrl_if.sv
// Request/response handshake and CAM search/write port of the CAM lookup sequencer.
// master: requester plus CAM side; slave: the sequencer itself.
interface cam_lookup_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_index;
    logic       rsp_hit;
    logic       rsp_new;
    logic       rsp_evict;
    logic       rsp_err;

    logic       cam_enable;
    logic       cam_write;
    logic [4:0] cam_addr;
    logic [7:0] cam_data;
    logic [4:0] cam_out;
    logic       cam_found;

    modport master (
        output req_valid, req_data, rsp_ready, cam_out, cam_found,
        input  req_ready, rsp_valid, rsp_index, rsp_hit, rsp_new, rsp_evict, rsp_err,
        input  cam_enable, cam_write, cam_addr, cam_data
    );

    modport slave (
        input  req_valid, req_data, rsp_ready, cam_out, cam_found,
        output req_ready, rsp_valid, rsp_index, rsp_hit, rsp_new, rsp_evict, rsp_err,
        output cam_enable, cam_write, cam_addr, cam_data
    );
endinterface

// File: rtl/cam_lookup_ctrl.sv
// Sequencer in front of a 16-entry byte CAM: searches each key, allocates a slot
// round-robin on a miss, and returns index plus hit/new/evict/err flags.
module cam_lookup_ctrl #(
    parameter int NB_MEM    = 16,
    parameter int SIZE_ADDR = 4
) (
    input  logic             clk,
    input  logic             rst,
    cam_lookup_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        EVAL   = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam int                   C_LAST_I = NB_MEM - 1;
    localparam logic [SIZE_ADDR:0]   C_FULL   = NB_MEM[SIZE_ADDR:0];
    localparam logic [SIZE_ADDR-1:0] C_LAST   = C_LAST_I[SIZE_ADDR-1:0];

    state_t               r_state;
    logic [7:0]           r_key;
    logic [SIZE_ADDR-1:0] r_alloc_ptr;
    logic [SIZE_ADDR:0]   r_count;

    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic [4:0]           r_rsp_index;
    logic                 r_rsp_hit;
    logic                 r_rsp_new;
    logic                 r_rsp_evict;
    logic                 r_rsp_err;

    logic                 r_cam_enable;
    logic                 r_cam_write;
    logic [4:0]           r_cam_addr;

    logic                 w_req_fire;
    logic                 w_full;

    assign w_req_fire = bus.req_valid && r_req_ready;
    assign w_full     = (r_count == C_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_key        <= 8'h00;
            r_alloc_ptr  <= '0;
            r_count      <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_index  <= 5'd0;
            r_rsp_hit    <= 1'b0;
            r_rsp_new    <= 1'b0;
            r_rsp_evict  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_cam_enable <= 1'b0;
            r_cam_write  <= 1'b0;
            r_cam_addr   <= 5'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_fire) begin
                        r_key       <= bus.req_data;
                        r_req_ready <= 1'b0;
                        // 8'h00 marks an empty CAM slot, so it is never looked up.
                        if (bus.req_data == 8'h00) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_index <= 5'd0;
                            r_state     <= RESP;
                        end else begin
                            r_cam_enable <= 1'b1;
                            r_state      <= SEARCH;
                        end
                    end
                end

                SEARCH: begin
                    r_cam_enable <= 1'b0;
                    r_state      <= EVAL;
                end

                EVAL: begin
                    if (bus.cam_found) begin
                        r_rsp_hit   <= 1'b1;
                        r_rsp_index <= bus.cam_out;
                        r_state     <= RESP;
                    end else begin
                        // The miss just cleared the CAM result register, which
                        // the CAM requires before it will take a write.
                        r_cam_write <= 1'b1;
                        r_cam_addr  <= 5'({1'b0, r_alloc_ptr});
                        r_state     <= WRITE;
                    end
                end

                WRITE: begin
                    r_cam_write <= 1'b0;
                    r_cam_addr  <= 5'd0;
                    r_rsp_new   <= 1'b1;
                    r_rsp_index <= 5'({1'b0, r_alloc_ptr});
                    r_rsp_evict <= w_full;
                    r_alloc_ptr <= (r_alloc_ptr == C_LAST) ? '0 : r_alloc_ptr + 1'b1;
                    if (!w_full) begin
                        r_count <= r_count + 1'b1;
                    end
                    r_state <= RESP;
                end

                RESP: begin
                    // Flags settle on entry; rsp_valid follows one cycle later.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_index <= 5'd0;
                        r_rsp_hit   <= 1'b0;
                        r_rsp_new   <= 1'b0;
                        r_rsp_evict <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_index  = r_rsp_index;
    assign bus.rsp_hit    = r_rsp_hit;
    assign bus.rsp_new    = r_rsp_new;
    assign bus.rsp_evict  = r_rsp_evict;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.cam_enable = r_cam_enable;
    assign bus.cam_write  = r_cam_write;
    assign bus.cam_addr   = r_cam_addr;
    assign bus.cam_data   = r_key;

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Bench for cam_lookup_ctrl: behavioural CAM, table-level reference model,
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_cam_lookup_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cam_lookup_ctrl_if bus();

    cam_lookup_ctrl #(.NB_MEM(16), .SIZE_ADDR(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural CAM: search registers found/index; write only when result is clear.
    logic [7:0] cam_mem [16];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) cam_mem[i] <= 8'h00;
            bus.cam_found <= 1'b0;
            bus.cam_out   <= 5'd0;
        end else if (bus.cam_enable && !bus.cam_write) begin
            bus.cam_found <= 1'b0;
            bus.cam_out   <= 5'd0;
            for (int i = 15; i >= 0; i--) begin
                if (cam_mem[i] == bus.cam_data) begin
                    bus.cam_found <= 1'b1;
                    bus.cam_out   <= 5'(i);
                end
            end
        end else if (bus.cam_write && !bus.cam_enable && !bus.cam_found && bus.cam_out == 5'd0) begin
            cam_mem[bus.cam_addr[3:0]] <= bus.cam_data;
        end
    end

    // Reference model: slot contents, FIFO pointer, fill count.
    int mdl_tab [16];
    int mdl_ptr, mdl_cnt, fidx;

    bit pend = 0, in_rsp = 0, rel_seen = 0;
    int pe_key, pe_idx, pe_hit, pe_new, pe_evict, pe_err, pe_lat;
    int hs_edge, en_cnt, wr_cnt, snap;
    int lr_idx, lr_hit, lr_new, lr_evict, lr_err, lr_lat, lr_en, lr_wr, lr_waddr;
    int n_rsp = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", int'(bus.req_ready), 1);
            chk("rst_rsp_flags", int'({bus.rsp_valid, bus.rsp_hit, bus.rsp_new, bus.rsp_evict, bus.rsp_err}), 0);
            chk("rst_rsp_index", int'(bus.rsp_index), 0);
            chk("rst_cam_ctrl", int'({bus.cam_enable, bus.cam_write}), 0);
            chk("rst_cam_addr", int'(bus.cam_addr), 0);
            chk("rst_cam_data", int'(bus.cam_data), 0);
            pend = 0; in_rsp = 0; rel_seen = 0;
            for (int i = 0; i < 16; i++) mdl_tab[i] = 0;
            mdl_ptr = 0; mdl_cnt = 0;
        end else begin
            chk("en_wr_exclusive", int'(bus.cam_enable && bus.cam_write), 0);
            chk("cam_addr_msb", int'(bus.cam_addr[4]), 0);
            if (rel_seen) begin
                chk("post_rel_valid", int'(bus.rsp_valid), 0);
                chk("post_rel_ready", int'(bus.req_ready), 1);
                rel_seen = 0;
            end
            if (pend) begin
                if (cyc >= hs_edge) chk("busy_req_ready", int'(bus.req_ready), 0);
                if (bus.cam_enable) begin
                    en_cnt++;
                    chk("search_data", int'(bus.cam_data), pe_key);
                end
                if (bus.cam_write) begin
                    wr_cnt++;
                    lr_waddr = int'(bus.cam_addr);
                    chk("write_addr", int'(bus.cam_addr), pe_idx);
                    chk("write_data", int'(bus.cam_data), pe_key);
                end
                if (bus.rsp_valid && !in_rsp) begin
                    in_rsp = 1;
                    n_rsp++;
                    lr_idx = int'(bus.rsp_index); lr_hit = int'(bus.rsp_hit);
                    lr_new = int'(bus.rsp_new);   lr_evict = int'(bus.rsp_evict);
                    lr_err = int'(bus.rsp_err);   lr_lat = cyc - hs_edge;
                    lr_en = en_cnt;               lr_wr = wr_cnt;
                    chk("rsp_index", lr_idx, pe_idx);
                    chk("rsp_hit", lr_hit, pe_hit);
                    chk("rsp_new", lr_new, pe_new);
                    chk("rsp_evict", lr_evict, pe_evict);
                    chk("rsp_err", lr_err, pe_err);
                    chk("rsp_latency", lr_lat, pe_lat);
                    chk("search_count", en_cnt, pe_err ? 0 : 1);
                    chk("write_count", wr_cnt, pe_new);
                    snap = int'({bus.rsp_index, bus.rsp_hit, bus.rsp_new, bus.rsp_evict, bus.rsp_err});
                end else if (bus.rsp_valid) begin
                    chk("rsp_stable", int'({bus.rsp_index, bus.rsp_hit, bus.rsp_new, bus.rsp_evict, bus.rsp_err}), snap);
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    pend = 0; in_rsp = 0; rel_seen = 1;
                end
            end else begin
                chk("no_spurious_rsp", int'(bus.rsp_valid), 0);
                chk("idle_cam_ctrl", int'({bus.cam_enable, bus.cam_write}), 0);
            end
            if (bus.req_valid && bus.req_ready) begin
                pe_key = int'(bus.req_data);
                pe_hit = 0; pe_new = 0; pe_evict = 0; pe_err = 0; pe_idx = 0;
                if (pe_key == 0) begin
                    pe_err = 1; pe_lat = 1;
                end else begin
                    fidx = -1;
                    for (int i = 15; i >= 0; i--) if (mdl_tab[i] == pe_key) fidx = i;
                    if (fidx >= 0) begin
                        pe_hit = 1; pe_idx = fidx; pe_lat = 3;
                    end else begin
                        pe_new = 1; pe_idx = mdl_ptr; pe_lat = 4;
                        pe_evict = (mdl_cnt == 16) ? 1 : 0;
                        mdl_tab[mdl_ptr] = pe_key;
                        mdl_ptr = (mdl_ptr + 1) % 16;
                        if (mdl_cnt < 16) mdl_cnt++;
                    end
                end
                pend = 1; hs_edge = cyc + 1; en_cnt = 0; wr_cnt = 0;
            end
        end
    end

    task automatic do_req(input logic [7:0] key, input int hold);
        int t;
        t = 0;
        while (!bus.req_ready && t < 20) begin @(posedge clk); #1; t++; end
        if (!bus.req_ready) begin chk("req_ready_timeout", int'(bus.req_ready), 1); return; end
        bus.req_valid = 1'b1;
        bus.req_data  = key;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        t = 0;
        while (!bus.rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
        if (!bus.rsp_valid) begin chk("rsp_timeout", int'(bus.rsp_valid), 1); return; end
        for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic req_lit(input string nm, input logic [7:0] key, input int hold,
                           input int idx, input int hit, input int nw, input int ev,
                           input int er, input int lat);
        int n0;
        n0 = n_rsp;
        do_req(key, hold);
        chk({nm, "_one_rsp"}, n_rsp, n0 + 1);
        chk({nm, "_idx"}, lr_idx, idx);
        chk({nm, "_flags"}, lr_hit * 8 + lr_new * 4 + lr_evict * 2 + lr_err, hit * 8 + nw * 4 + ev * 2 + er);
        chk({nm, "_lat"}, lr_lat, lat);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, t;
        logic [7:0] k;
        bus.req_valid = 1'b0;
        bus.req_data  = 8'h00;
        bus.rsp_ready = 1'b0;
        do_reset();

        req_lit("a5_miss", 8'hA5, 0, 0, 0, 1, 0, 0, 4);
        chk("a5_miss_waddr", lr_waddr, 0);
        chk("a5_miss_writes", lr_wr, 1);
        req_lit("a5_hit", 8'hA5, 0, 0, 1, 0, 0, 0, 3);
        chk("a5_hit_searches", lr_en, 1);
        chk("a5_hit_writes", lr_wr, 0);

        do_reset();
        for (int i = 1; i <= 16; i++) req_lit("fill", 8'(i), 0, i - 1, 0, 1, 0, 0, 4);
        req_lit("evict_11", 8'h11, 0, 0, 0, 1, 1, 0, 4);
        req_lit("rewrite_01", 8'h01, 0, 1, 0, 1, 1, 0, 4);

        req_lit("reserved", 8'h00, 0, 0, 0, 0, 0, 1, 1);
        chk("reserved_searches", lr_en, 0);
        chk("reserved_writes", lr_wr, 0);

        req_lit("hold5_hit", 8'h11, 5, 0, 1, 0, 0, 0, 3);

        do_reset();
        bus.req_valid = 1'b1;
        bus.req_data  = 8'h3C;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        t = 0;
        while (!bus.cam_write && t < 10) begin @(posedge clk); #1; t++; end
        chk("abort_reached_write", int'(bus.cam_write), 1);
        n0 = n_rsp;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_rsp", n_rsp, n0);
        req_lit("after_abort", 8'h3C, 0, 0, 0, 1, 0, 0, 4);

        for (int i = 0; i < 400; i++) begin
            k = ($urandom_range(0, 11) == 0) ? 8'h00 : 8'($urandom_range(1, 30));
            do_req(k, $urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_lookup_ctrl.md
Name: cam_lookup_ctrl

Overview:
- Request sequencer directly upstream of the 16-entry byte CAM.
- Accepts one byte key per valid/ready transaction and drives the CAM search port. On a miss it allocates a slot round-robin and writes the key into it.
- Returns the slot index and hit/new/evict flags on a valid/ready response port.
- Integration drives the CAM's active-low reset from the inverse of this block's rst.

Parameters:
- NB_MEM, 16, number of CAM slots; must equal the CAM's NB_MEM.
- SIZE_ADDR, 4, slot index width, log2(NB_MEM).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request key present.
- req_ready  output  1  block can accept a request.
- req_data  input  8  key byte.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_index  output  5  slot index, {1'b0, idx[SIZE_ADDR-1:0]}.
- rsp_hit  output  1  key was already stored.
- rsp_new  output  1  key was written into a slot by this request.
- rsp_evict  output  1  the write overwrote a live entry (table full).
- rsp_err  output  1  key was reserved value 8'h00; no CAM access made.
- cam_enable  output  1  to CAM enable.
- cam_write  output  1  to CAM write.
- cam_addr  output  5  to CAM addr; bit 4 is always 0.
- cam_data  output  8  to CAM data; always equals the captured key.
- cam_out  input  5  from CAM out.
- cam_found  input  1  from CAM found.

Behaviour:
- Reset (asynchronous, rst=1):
  - State is IDLE.
  - req_ready=1.
  - All rsp_* outputs = 0.
  - cam_enable=0, cam_write=0, cam_addr=0.
  - Captured key = 0.
  - alloc_ptr=0, count=0.
- States: IDLE, SEARCH, EVAL, WRITE, RESP.
- req_ready=1 only in IDLE; the handshake completes when req_valid && req_ready.
- IDLE:
  - On a handshake, capture req_data into key.
  - key==8'h00 -> RESP with rsp_err=1, rsp_index=0, all other flags 0.
  - Otherwise -> SEARCH.
- SEARCH (1 cycle): cam_enable=1, cam_write=0 -> EVAL.
- EVAL:
  - Samples cam_found/cam_out, which are registered by the CAM on the SEARCH edge.
  - cam_found=1 -> RESP, rsp_hit=1, rsp_index=cam_out.
  - cam_found=0 -> WRITE.
- WRITE (1 cycle):
  - Drive cam_write=1, cam_enable=0, cam_addr={1'b0, alloc_ptr}.
  - WRITE must immediately follow a missed SEARCH. That miss zeroes the CAM's internal result register, which is the CAM's precondition for accepting the write.
  - rsp_new=1, rsp_index={1'b0, alloc_ptr}.
  - rsp_evict=1 if count==NB_MEM at entry to WRITE.
  - alloc_ptr increments modulo NB_MEM, wrapping NB_MEM-1 -> 0.
  - count increments, saturating at NB_MEM.
  - -> RESP.
- RESP:
  - rsp_valid=1; rsp_* are held stable until rsp_ready=1.
  - On rsp_valid && rsp_ready, clear rsp_valid and all flags -> IDLE.
  - The next request is accepted no earlier than the following cycle; there is no same-cycle turnaround.
- Latency from request handshake edge to rsp_valid rising:
  - Hit: 3 cycles.
  - Miss: 4 cycles.
  - Reserved key: 1 cycle.
- cam_enable and cam_write are never high together. Both are 0 in IDLE, EVAL and RESP.
- 8'h00 is reserved as the empty-slot marker, because CAM slots reset to zero. The block never searches for or writes 8'h00.
- Replacement is FIFO order by alloc_ptr. Hits do not change alloc_ptr or count.
- Duplicate keys cannot arise, because a write only follows a miss.
- rst asserted mid-transaction aborts the transaction immediately to the reset values. No response is issued for the aborted request.

Test Plan:
- Reset then key 8'hA5 -> miss: cam_write pulse with cam_addr=0; response rsp_new=1, rsp_index=0, rsp_evict=0, 4 cycles after handshake.
- Repeat key 8'hA5 -> one cam_enable pulse, no cam_write; response rsp_hit=1, rsp_index=0, 3 cycles after handshake.
- Keys 8'h01..8'h10 after reset -> rsp_index 0..15, all rsp_new=1. Then key 8'h11 -> rsp_index=0, rsp_evict=1. Then key 8'h01 -> miss, written at index 1.
- Key 8'h00 -> rsp_err=1 one cycle after handshake; cam_enable and cam_write stay 0 throughout.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable and req_ready=0 for the whole hold. Release -> IDLE, req_ready=1 next cycle.
- Assert rst during WRITE of key 8'h3C -> all outputs return to reset values and no response is issued. After release, key 8'h3C -> rsp_index=0, rsp_new=1.
